stage_pipe_regs: RTL and testbench



---
 rtl/stage_pipe_regs.sv | 134 +++++++++++++
 tb/tb_stage_pipe_regs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stage_pipe_regs.sv
// Pipeline registers between fetch, decode/execute and memory/writeback,
// with boot bubble, global stall, single-slot kill on redirect and instret.
module stage_pipe_regs #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_inst,
  input  logic [31:0] fetch_pc,
  input  logic        stall,
  input  logic        redirect,
  output logic [31:0] s2_inst,
  output logic [31:0] s2_pc,
  output logic        s2_valid,
  output logic [31:0] s3_inst,
  output logic [31:0] s3_pc,
  output logic        s3_valid,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic [31:0] s2_pc_q, s2_pc_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s3_inst_q, s3_inst_d;
  logic [31:0] s3_pc_q, s3_pc_d;
  logic        s3_valid_q, s3_valid_d;
  logic [31:0] instret_q, instret_d;
  logic        shift_s;
  logic        load_s;

  // Next-state decode: shift_s advances the pipe, load_s allows imem data into s2.
  always_comb begin
    state_d = state_q;
    shift_s = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (stall) begin
          state_d = ST_BOOT;
        end else begin
          // imem has no valid word yet, so the first slot is always a bubble
          state_d = ST_RUN;
          shift_s = 1'b1;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          shift_s = 1'b1;
          load_s  = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
        shift_s = 1'b0;
        load_s  = 1'b0;
      end
    endcase
  end

  // Pipeline register and retired-count next values.
  always_comb begin
    s2_inst_d  = s2_inst_q;
    s2_pc_d    = s2_pc_q;
    s2_valid_d = s2_valid_q;
    s3_inst_d  = s3_inst_q;
    s3_pc_d    = s3_pc_q;
    s3_valid_d = s3_valid_q;
    instret_d  = instret_q;
    if (shift_s) begin
      s3_inst_d  = s2_inst_q;
      s3_pc_d    = s2_pc_q;
      s3_valid_d = s2_valid_q;
      s2_pc_d    = fetch_pc;
      if (load_s && !redirect) begin
        s2_inst_d  = imem_inst;
        s2_valid_d = 1'b1;
      end else begin
        s2_inst_d  = NOP_INST;
        s2_valid_d = 1'b0;
      end
    end else begin
      s3_inst_d  = s3_inst_q;
      s2_inst_d  = s2_inst_q;
    end
    if (!stall && s3_valid_q) begin
      instret_d = instret_q + 32'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // State and pipeline flops with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      s2_inst_q  <= NOP_INST;
      s2_pc_q    <= RESET_PC;
      s2_valid_q <= 1'b0;
      s3_inst_q  <= NOP_INST;
      s3_pc_q    <= RESET_PC;
      s3_valid_q <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      s2_inst_q  <= s2_inst_d;
      s2_pc_q    <= s2_pc_d;
      s2_valid_q <= s2_valid_d;
      s3_inst_q  <= s3_inst_d;
      s3_pc_q    <= s3_pc_d;
      s3_valid_q <= s3_valid_d;
      instret_q  <= instret_d;
    end
  end

  assign s2_inst  = s2_inst_q;
  assign s2_pc    = s2_pc_q;
  assign s2_valid = s2_valid_q;
  assign s3_inst  = s3_inst_q;
  assign s3_pc    = s3_pc_q;
  assign s3_valid = s3_valid_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_stage_pipe_regs.sv
// Directed bench for stage_pipe_regs: boot, redirect, stall, wrap, async reset.
module tb_stage_pipe_regs;
  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h00A0_0093;
  localparam logic [31:0] I1  = 32'h0010_0113;
  localparam logic [31:0] I2  = 32'h0020_8133;
  localparam logic [31:0] I3  = 32'h0030_0193;
  localparam logic [31:0] I4  = 32'h0040_0213;
  localparam logic [31:0] I5  = 32'h0050_0293;
  localparam logic [31:0] I6  = 32'h0060_0313;
  localparam logic [31:0] I7  = 32'h0070_0393;
  localparam logic [31:0] I8  = 32'h0080_0413;
  localparam logic [31:0] I9  = 32'h0090_0493;
  localparam logic [31:0] I10 = 32'h00A0_0513;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_inst;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] s2_inst;
  logic [31:0] s2_pc;
  logic        s2_valid;
  logic [31:0] s3_inst;
  logic [31:0] s3_pc;
  logic        s3_valid;
  logic [31:0] instret;

  int checks;
  int errors;

  stage_pipe_regs #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_inst(imem_inst), .fetch_pc(fetch_pc),
    .stall(stall), .redirect(redirect),
    .s2_inst(s2_inst), .s2_pc(s2_pc), .s2_valid(s2_valid),
    .s3_inst(s3_inst), .s3_pc(s3_pc), .s3_valid(s3_valid),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic st, input logic rd);
    imem_inst = inst;
    fetch_pc  = pc;
    stall     = st;
    redirect  = rd;
  endtask

  task automatic check_pipe(input string tag, input logic [31:0] e2, input logic e2v,
                            input logic [31:0] e3, input logic e3v, input logic [31:0] ecnt);
    check({tag, "_s2_inst"}, s2_inst, e2);
    check({tag, "_s2_valid"}, {31'd0, s2_valid}, {31'd0, e2v});
    check({tag, "_s3_inst"}, s3_inst, e3);
    check({tag, "_s3_valid"}, {31'd0, s3_valid}, {31'd0, e3v});
    check({tag, "_instret"}, instret, ecnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(NOP, RST_PC, 1'b0, 1'b0);
    #12;
    check_pipe("reset", NOP, 1'b0, NOP, 1'b0, 32'd0);
    check("reset_s2_pc", s2_pc, RST_PC);
    check("reset_s3_pc", s3_pc, RST_PC);

    // Boot bubble then first real instruction
    rst_n = 1'b1;
    drive(I0, 32'h4000_0000, 1'b0, 1'b0);
    step();
    check_pipe("boot_e1", NOP, 1'b0, NOP, 1'b0, 32'd0);
    step();
    check_pipe("boot_e2", I0, 1'b1, NOP, 1'b0, 32'd0);
    check("boot_e2_s2_pc", s2_pc, 32'h4000_0000);
    drive(I1, 32'h4000_0004, 1'b0, 1'b0);
    step();
    check_pipe("run_e3", I1, 1'b1, I0, 1'b1, 32'd0);
    check("run_e3_s3_pc", s3_pc, 32'h4000_0000);

    // Redirect kills the wrong-path word
    drive(I2, 32'h4000_0008, 1'b0, 1'b1);
    step();
    check_pipe("redir_e4", NOP, 1'b0, I1, 1'b1, 32'd1);
    check("redir_e4_s2_pc", s2_pc, 32'h4000_0008);
    drive(I3, 32'h4000_0020, 1'b0, 1'b0);
    step();
    check_pipe("redir_e5", I3, 1'b1, NOP, 1'b0, 32'd2);
    check("redir_e5_s3_pc", s3_pc, 32'h4000_0008);
    drive(I4, 32'h4000_0024, 1'b0, 1'b0);
    step();
    check_pipe("redir_e6", I4, 1'b1, I3, 1'b1, 32'd2);

    // Three stalled edges freeze everything
    drive(I5, 32'h4000_0028, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_pipe("stall", I4, 1'b1, I3, 1'b1, 32'd2);
      check("stall_s2_pc", s2_pc, 32'h4000_0024);
    end
    stall = 1'b0;
    step();
    check_pipe("unstall_e10", I5, 1'b1, I4, 1'b1, 32'd3);
    drive(I6, 32'h4000_002C, 1'b0, 1'b0);
    step();
    check_pipe("unstall_e11", I6, 1'b1, I5, 1'b1, 32'd4);

    // Stall with redirect held: kill only on first non-stalled edge
    drive(I7, 32'h4000_0030, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_pipe("stall_redir", I6, 1'b1, I5, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step();
    check_pipe("late_kill", NOP, 1'b0, I6, 1'b1, 32'd5);
    check("late_kill_s2_pc", s2_pc, 32'h4000_0030);
    drive(I8, 32'h4000_0040, 1'b0, 1'b0);
    step();
    check_pipe("after_kill", I8, 1'b1, NOP, 1'b0, 32'd6);

    // Back-to-back redirects
    drive(I9, 32'h4000_0044, 1'b0, 1'b1);
    step();
    check_pipe("b2b_1", NOP, 1'b0, I8, 1'b1, 32'd6);
    drive(I9, 32'h4000_0048, 1'b0, 1'b1);
    step();
    check_pipe("b2b_2", NOP, 1'b0, NOP, 1'b0, 32'd7);
    drive(I9, 32'h4000_0050, 1'b0, 1'b0);
    step();
    check_pipe("b2b_3", I9, 1'b1, NOP, 1'b0, 32'd7);
    drive(I10, 32'h4000_0054, 1'b0, 1'b0);
    step();
    check_pipe("b2b_4", I10, 1'b1, I9, 1'b1, 32'd7);

    // instret wrap via preload during a stall
    stall = 1'b1;
    force dut.instret_q = 32'hFFFF_FFFF;
    step();
    release dut.instret_q;
    #1;
    check("wrap_preload", instret, 32'hFFFF_FFFF);
    stall = 1'b0;
    step();
    check("wrap_zero", instret, 32'h0000_0000);
    check("wrap_s3_inst", s3_inst, I10);

    // Asynchronous reset while in HOLD
    stall = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_pipe("async_rst", NOP, 1'b0, NOP, 1'b0, 32'd0);
    check("async_rst_s2_pc", s2_pc, RST_PC);
    check("async_rst_s3_pc", s3_pc, RST_PC);
    #2;
    rst_n = 1'b1;
    drive(I0, 32'h4000_0000, 1'b0, 1'b0);
    step();
    check_pipe("reboot_e1", NOP, 1'b0, NOP, 1'b0, 32'd0);
    step();
    check_pipe("reboot_e2", I0, 1'b1, NOP, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
